// File: rtl/fir_tap_loader_if.sv
// fir_tap_loader_if: coefficient stream from the host to the tap loader.
//
// Handshake: a word moves on a rising CLK edge where cfg_valid and cfg_ready
// are both high. The host may raise cfg_valid at any time and change
// cfg_data freely while cfg_ready is low. cfg_valid without cfg_ready is
// simply not a transfer. cfg_ready is not combinationally dependent on
// cfg_valid.
//
// Signals:
//   cfg_valid  host -> loader  cfg_data holds a coefficient
//   cfg_data   host -> loader  coefficient, TAP_W bits, index order 0 first
//   cfg_ready  loader -> host  loader accepts cfg_data this cycle
// Modports: master (host side), slave (loader side).
interface fir_tap_loader_if #(
  parameter int TAP_W = 32
);
  logic             cfg_valid;
  logic [TAP_W-1:0] cfg_data;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/fir_tap_loader.sv
// fir_tap_loader: loads a full tap set into FIR_Filter_Core.
//
// Coefficients arrive on the cfg stream in index order. Each one is presented
// to the core as a 3-cycle slot: two cycles with tap_Transfer high and one gap
// cycle, with tap_Index/tap_Value stable throughout. en_FIR is held low from
// the start of a load until a settle window after the last tap has passed, so
// the core never sees a mixed coefficient set while running.
//
// Optional feature (macro FIR_TAP_SHADOW_EN): a shadow copy of the last full
// tap set, which cfg_replay rewrites into the core without host traffic.
// Without the macro, cfg_replay is always an illegal command.
//
// Ports:
//   CLK, areset_n   clock (rising edge) and asynchronous active-low reset
//   user_en         host request to run the filter
//   cfg_start       pulse: begin loading a new tap set
//   cfg_replay      pulse: rewrite the core from the shadow store
//   cfg             coefficient stream (slave side of fir_tap_loader_if)
//   cfg_busy        high in every state except IDLE
//   cfg_done        pulse: load complete, filter re-enabled next cycle
//   cfg_err         pulse: illegal command, ignored
//   tap_Transfer, tap_Index, tap_Value, en_FIR   to the core
//   state_dbg       current FSM state (debug)
// IDX_W must satisfy 2**IDX_W >= NUM_TAPS; SETTLE_CYCLES must be >= 1.
module fir_tap_loader #(
  parameter int NUM_TAPS      = 16,
  parameter int TAP_W         = 32,
  parameter int IDX_W         = 4,
  parameter int SETTLE_CYCLES = 18
) (
  input  logic                    CLK,
  input  logic                    areset_n,
  input  logic                    user_en,
  input  logic                    cfg_start,
  input  logic                    cfg_replay,
  fir_tap_loader_if.slave         cfg,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  output logic                    cfg_err,
  output logic                    tap_Transfer,
  output logic [IDX_W-1:0]        tap_Index,
  output logic signed [TAP_W-1:0] tap_Value,
  output logic                    en_FIR,
  output logic [2:0]              state_dbg
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_DRIVE1    = 3'd2,
    S_DRIVE2    = 3'd3,
    S_GAP       = 3'd4,
    S_SETTLE    = 3'd5
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             replay;   // current pass is sourced from the shadow store

  assign state_dbg = state;

`ifdef FIR_TAP_SHADOW_EN
  logic             shadow_valid;
  logic [TAP_W-1:0] shadow [NUM_TAPS];

  // Shadow store has no reset; shadow_valid alone says whether it is usable.
  always_ff @(posedge CLK) begin
    if (state == S_WAIT_DATA && !replay && cfg.cfg_valid) begin
      shadow[idx] <= cfg.cfg_data;
    end
  end
`endif

  always_ff @(posedge CLK or negedge areset_n) begin
    if (!areset_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      replay        <= 1'b0;
      cfg.cfg_ready <= 1'b0;
      cfg_busy      <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
      tap_Transfer  <= 1'b0;
      tap_Index     <= '0;
      tap_Value     <= '0;
      en_FIR        <= 1'b0;
`ifdef FIR_TAP_SHADOW_EN
      shadow_valid  <= 1'b0;
`endif
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;

      case (state)
        S_IDLE: begin
          en_FIR <= user_en;
          // cfg_start takes priority over a simultaneous cfg_replay.
          if (cfg_start) begin
            state         <= S_WAIT_DATA;
            idx           <= '0;
            replay        <= 1'b0;
            cfg_busy      <= 1'b1;
            cfg.cfg_ready <= 1'b1;
            en_FIR        <= 1'b0;
`ifdef FIR_TAP_SHADOW_EN
            shadow_valid  <= 1'b0;
`endif
          end else if (cfg_replay) begin
`ifdef FIR_TAP_SHADOW_EN
            if (shadow_valid) begin
              state    <= S_WAIT_DATA;
              idx      <= '0;
              replay   <= 1'b1;
              cfg_busy <= 1'b1;
              en_FIR   <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
            end
`else
            cfg_err <= 1'b1;
`endif
          end
        end

        S_WAIT_DATA: begin
`ifdef FIR_TAP_SHADOW_EN
          if (replay) begin
            // Replay spends exactly one cycle here, keeping the 4-cycle pace.
            state        <= S_DRIVE1;
            tap_Transfer <= 1'b1;
            tap_Index    <= idx;
            tap_Value    <= shadow[idx];
          end else
`endif
          if (cfg.cfg_valid) begin
            state         <= S_DRIVE1;
            cfg.cfg_ready <= 1'b0;
            tap_Transfer  <= 1'b1;
            tap_Index     <= idx;
            tap_Value     <= cfg.cfg_data;
          end
        end

        S_DRIVE1: begin
          state <= S_DRIVE2;
        end

        S_DRIVE2: begin
          state        <= S_GAP;
          tap_Transfer <= 1'b0;
        end

        S_GAP: begin
          if (idx == LAST_IDX) begin
            state    <= S_SETTLE;
            cnt      <= SETTLE_LOAD;
            // With a one-cycle window the done pulse lands in the first
            // SETTLE cycle.
            cfg_done <= (SETTLE_CYCLES == 1);
`ifdef FIR_TAP_SHADOW_EN
            shadow_valid <= 1'b1;
`endif
          end else begin
            state         <= S_WAIT_DATA;
            idx           <= idx + IDX_W'(1);
            cfg.cfg_ready <= !replay;
          end
        end

        S_SETTLE: begin
          // cfg_done is registered so it is high in the cycle the counter
          // reads 0; the following edge returns to IDLE and re-enables.
          if (cnt == '0) begin
            state    <= S_IDLE;
            cfg_busy <= 1'b0;
            replay   <= 1'b0;
            en_FIR   <= user_en;
          end else begin
            cnt      <= cnt - CNT_W'(1);
            cfg_done <= (cnt == CNT_W'(1));
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      // Commands while busy are rejected; the pass in progress is untouched.
      if (state != S_IDLE && (cfg_start || cfg_replay)) begin
        cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader: self-checking bench for fir_tap_loader.
// Cycle numbering in comments: the cycle in which cfg_start is high is
// cycle 1; a full unstalled load has cfg_done high in cycle 83.
module tb_fir_tap_loader;
  localparam int NUM_TAPS = 16;
  localparam int TAP_W    = 32;
  localparam int IDX_W    = 4;
  localparam int SETTLE   = 18;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic areset_n = 1'b0;
  logic user_en = 1'b0;
  logic cfg_start = 1'b0;
  logic cfg_replay = 1'b0;
  logic cfg_busy, cfg_done, cfg_err, tap_Transfer, en_FIR;
  logic [IDX_W-1:0] tap_Index;
  logic signed [TAP_W-1:0] tap_Value;
  logic [2:0] state_dbg;

  always #5 CLK = ~CLK;

  fir_tap_loader_if #(.TAP_W(TAP_W)) bus ();

  fir_tap_loader #(
    .NUM_TAPS(NUM_TAPS), .TAP_W(TAP_W), .IDX_W(IDX_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .CLK(CLK), .areset_n(areset_n), .user_en(user_en), .cfg_start(cfg_start),
    .cfg_replay(cfg_replay), .cfg(bus), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .tap_Transfer(tap_Transfer), .tap_Index(tap_Index),
    .tap_Value(tap_Value), .en_FIR(en_FIR), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / scoreboard ----------------
  logic [TAP_W-1:0] vals [NUM_TAPS];
  logic [IDX_W+TAP_W-1:0] exp_q[$];   // expected {index, value} per write, in order

  task automatic build_model();
    exp_q.delete();
    for (int i = 0; i < NUM_TAPS; i++) exp_q.push_back({IDX_W'(i), vals[i]});
  endtask

  // ---------------- monitor (records only) ----------------
  typedef struct {
    int len; bit stable; logic [IDX_W-1:0] idx; logic [TAP_W-1:0] val; int rise;
  } wr_t;
  wr_t got_q[$];
  int done_q[$], err_q[$], busy_rise_q[$], en_fall_q[$], en_rise_q[$], ready_rise_q[$];
  int ready_hi = 0;
  logic prev_t = 1'b0, prev_busy = 1'b0, prev_en = 1'b0, prev_rdy = 1'b0;
  wr_t cur;

  always @(negedge CLK) begin
    if (tap_Transfer) begin
      if (!prev_t) begin
        cur.len = 1; cur.stable = 1; cur.idx = tap_Index; cur.val = tap_Value; cur.rise = cyc;
      end else begin
        cur.len++;
        if (tap_Index !== cur.idx || tap_Value !== cur.val) cur.stable = 0;
      end
    end else if (prev_t) begin
      if (tap_Index !== cur.idx || tap_Value !== cur.val) cur.stable = 0;
      got_q.push_back(cur);
    end
    if (cfg_done) done_q.push_back(cyc);
    if (cfg_err) err_q.push_back(cyc);
    if (cfg_busy && !prev_busy) busy_rise_q.push_back(cyc);
    if (!en_FIR && prev_en) en_fall_q.push_back(cyc);
    if (en_FIR && !prev_en) en_rise_q.push_back(cyc);
    if (bus.cfg_ready && !prev_rdy) ready_rise_q.push_back(cyc);
    if (bus.cfg_ready) ready_hi++;
    prev_t = tap_Transfer; prev_busy = cfg_busy; prev_en = en_FIR; prev_rdy = bus.cfg_ready;
  end

  task automatic clear_logs();
    got_q.delete(); done_q.delete(); err_q.delete(); busy_rise_q.delete();
    en_fall_q.delete(); en_rise_q.delete(); ready_rise_q.delete(); ready_hi = 0;
  endtask

  // ---------------- driver tasks ----------------
  int stall_good;
  int poke_cyc;

  // Offer one coefficient; returns #1 after the accepting edge.
  task automatic push_tap(input logic [TAP_W-1:0] v);
    int n;
    n = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = v;
    @(negedge CLK);
    while (bus.cfg_ready !== 1'b1 && n < 200) begin n++; @(negedge CLK); end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL ready_timeout cfg_ready never rose, waited %0d cycles", n);
    end
    @(posedge CLK); #1;
  endtask

  task automatic drive_load(input bit with_replay, input int poke_at, input int stall_at,
                            output int t0);
    bus.cfg_valid = 1'b0;
    @(posedge CLK); #1;
    cfg_start = 1'b1; cfg_replay = with_replay; t0 = cyc;
    @(posedge CLK); #1;
    cfg_start = 1'b0; cfg_replay = 1'b0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      push_tap(vals[i]);
      if (i == poke_at) begin
        @(posedge CLK); #1; cfg_start = 1'b1;      // DRIVE2 of this tap
        @(posedge CLK); #1; cfg_start = 1'b0; poke_cyc = cyc;
      end
      if (i == stall_at) begin
        bus.cfg_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        repeat (10) begin
          @(negedge CLK);
          if (bus.cfg_ready === 1'b1 && tap_Transfer === 1'b0) stall_good++;
          @(posedge CLK); #1;
        end
      end
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < budget) begin @(negedge CLK); #1; n++; end
    if (done_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout no cfg_done within %0d cycles", budget);
    end
  endtask

  task automatic pulse_replay(output int t0);
    @(posedge CLK); #1; cfg_replay = 1'b1; t0 = cyc;
    @(posedge CLK); #1; cfg_replay = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.cfg_valid = 1'b0; bus.cfg_data = '0;
    user_en = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({cfg_busy, cfg_done, cfg_err, tap_Transfer, tap_Index, tap_Value, en_FIR,
         bus.cfg_ready, state_dbg} !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b err=%b xfer=%b idx=%0d val=%h en=%b rdy=%b want all 0",
               cfg_busy, cfg_done, cfg_err, tap_Transfer, tap_Index, tap_Value, en_FIR, bus.cfg_ready);
    end
    @(posedge CLK); #2 areset_n = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (en_FIR !== 1'b1 || {cfg_busy, cfg_done, cfg_err, tap_Transfer, bus.cfg_ready} !== '0) begin
      errors++;
      $display("FAIL reset_release en=%b busy=%b done=%b err=%b xfer=%b rdy=%b want en=1 others 0",
               en_FIR, cfg_busy, cfg_done, cfg_err, tap_Transfer, bus.cfg_ready);
    end
  endtask

  // cfg_replay with no usable shadow: error pulse, no state change.
  task automatic test_replay_no_shadow();
    int t0;
    clear_logs();
    pulse_replay(t0);
    repeat (4) @(negedge CLK);
    #1;
    checks++;
    if (err_q.size() != 1 || err_q[0] != t0 + 1) begin
      errors++;
      $display("FAIL replay_err count=%0d first=%0d want one pulse at %0d",
               err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, t0 + 1);
    end
    checks++;
    if (busy_rise_q.size() != 0 || en_FIR !== 1'b1) begin
      errors++;
      $display("FAIL replay_idle busy_rises=%0d en=%b want 0 rises, en=1", busy_rise_q.size(), en_FIR);
    end
  endtask

  task automatic test_full_load();
    int t0;
    for (int i = 0; i < NUM_TAPS; i++) vals[i] = TAP_W'(i + 1);
    build_model();
    clear_logs();
    drive_load(1'b0, -1, -1, t0);
    wait_done(200);
    @(negedge CLK); #1;
    checks++;
    if (busy_rise_q.size() != 1 || busy_rise_q[0] != t0 + 1 || ready_rise_q.size() == 0 ||
        ready_rise_q[0] != t0 + 1 || en_fall_q.size() != 1 || en_fall_q[0] != t0 + 1) begin
      errors++;
      $display("FAIL start_response busy@%0d rdy@%0d enfall@%0d want all %0d",
               (busy_rise_q.size() > 0) ? busy_rise_q[0] : -1,
               (ready_rise_q.size() > 0) ? ready_rise_q[0] : -1,
               (en_fall_q.size() > 0) ? en_fall_q[0] : -1, t0 + 1);
    end
    checks++;
    if (got_q.size() != NUM_TAPS) begin
      errors++; $display("FAIL full_count got %0d writes want %0d", got_q.size(), NUM_TAPS);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if ({got_q[i].idx, got_q[i].val} !== exp_q[i] || got_q[i].len != 2 || !got_q[i].stable ||
          (i > 0 && got_q[i].rise - got_q[i-1].rise != 4)) begin
        errors++;
        $display("FAIL full_write%0d got idx=%0d val=%h len=%0d stable=%0d want %h len 2 spacing 4",
                 i, got_q[i].idx, got_q[i].val, got_q[i].len, got_q[i].stable, exp_q[i]);
      end
    end
    checks++;   // cycle 83 counting the start cycle as cycle 1
    if (done_q.size() != 1 || done_q[0] != t0 + 82) begin
      errors++;
      $display("FAIL full_done count=%0d at=%0d want one pulse at %0d",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, t0 + 82);
    end
    checks++;
    if (en_rise_q.size() != 1 || en_rise_q[0] != t0 + 83 || cfg_busy !== 1'b0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL full_reenable en_rise=%0d busy=%b errs=%0d want rise at %0d busy 0 no errors",
               (en_rise_q.size() > 0) ? en_rise_q[0] : -1, cfg_busy, err_q.size(), t0 + 83);
    end
  endtask

  task automatic test_replay_after_load();
    int t0;
    clear_logs();
    pulse_replay(t0);
`ifdef FIR_TAP_SHADOW_EN
    wait_done(200);
    @(negedge CLK); #1;
    checks++;
    if (got_q.size() != NUM_TAPS || ready_hi != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL replay_pass writes=%0d ready_cycles=%0d errs=%0d want %0d 0 0",
               got_q.size(), ready_hi, err_q.size(), NUM_TAPS);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if ({got_q[i].idx, got_q[i].val} !== exp_q[i] || got_q[i].len != 2 ||
          (i > 0 && got_q[i].rise - got_q[i-1].rise != 4)) begin
        errors++;
        $display("FAIL replay_write%0d got idx=%0d val=%h len=%0d want %h", i,
                 got_q[i].idx, got_q[i].val, got_q[i].len, exp_q[i]);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != t0 + 82) begin
      errors++;
      $display("FAIL replay_done at=%0d want %0d", (done_q.size() > 0) ? done_q[0] : -1, t0 + 82);
    end
`else
    repeat (4) @(negedge CLK);
    #1;
    checks++;
    if (err_q.size() != 1 || err_q[0] != t0 + 1 || busy_rise_q.size() != 0) begin
      errors++;
      $display("FAIL replay_err count=%0d busy_rises=%0d want 1 err at %0d and no busy",
               err_q.size(), busy_rise_q.size(), t0 + 1);
    end
`endif
  endtask

  task automatic test_stall();
    int t0;
    for (int i = 0; i < NUM_TAPS; i++) vals[i] = $urandom;
    build_model();
    clear_logs();
    stall_good = 0;
    drive_load(1'b0, -1, 5, t0);
    wait_done(300);
    #1;
    checks++;
    if (stall_good != 10) begin
      errors++; $display("FAIL stall_hold good_cycles=%0d want 10", stall_good);
    end
    checks++;
    if (got_q.size() != NUM_TAPS) begin
      errors++; $display("FAIL stall_count got %0d want %0d", got_q.size(), NUM_TAPS);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if ({got_q[i].idx, got_q[i].val} !== exp_q[i] || got_q[i].len != 2 || !got_q[i].stable) begin
        errors++;
        $display("FAIL stall_write%0d got idx=%0d val=%h len=%0d want %h", i,
                 got_q[i].idx, got_q[i].val, got_q[i].len, exp_q[i]);
      end
    end
    if (got_q.size() == NUM_TAPS) begin
      checks++;
      if (got_q[6].rise - got_q[5].rise != 14 ||
          done_q.size() != 1 || done_q[0] != got_q[NUM_TAPS-1].rise + SETTLE + 2) begin
        errors++;
        $display("FAIL stall_timing gap=%0d done=%0d want gap 14 done %0d",
                 got_q[6].rise - got_q[5].rise, (done_q.size() > 0) ? done_q[0] : -1,
                 got_q[NUM_TAPS-1].rise + SETTLE + 2);
      end
    end
  endtask

  task automatic test_start_during_load();
    int t0;
    for (int i = 0; i < NUM_TAPS; i++) vals[i] = $urandom;
    build_model();
    clear_logs();
    drive_load(1'b0, 3, -1, t0);
    wait_done(300);
    #1;
    checks++;
    if (err_q.size() != 1 || err_q[0] != poke_cyc) begin
      errors++;
      $display("FAIL busy_start_err count=%0d at=%0d want one at %0d",
               err_q.size(), (err_q.size() > 0) ? err_q[0] : -1, poke_cyc);
    end
    checks++;
    if (got_q.size() != NUM_TAPS || busy_rise_q.size() != 1) begin
      errors++;
      $display("FAIL busy_start_count writes=%0d busy_rises=%0d want %0d 1",
               got_q.size(), busy_rise_q.size(), NUM_TAPS);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if ({got_q[i].idx, got_q[i].val} !== exp_q[i] || got_q[i].len != 2) begin
        errors++;
        $display("FAIL busy_start_write%0d got idx=%0d val=%h want %h", i,
                 got_q[i].idx, got_q[i].val, exp_q[i]);
      end
    end
  endtask

  task automatic test_start_replay_together();
    int t0;
    for (int i = 0; i < NUM_TAPS; i++) vals[i] = $urandom;
    build_model();
    clear_logs();
    drive_load(1'b1, -1, -1, t0);
    wait_done(300);
    #1;
    checks++;
    if (err_q.size() != 0 || busy_rise_q.size() != 1 || busy_rise_q[0] != t0 + 1 ||
        done_q.size() != 1 || done_q[0] != t0 + 82) begin
      errors++;
      $display("FAIL start_replay errs=%0d busy@%0d done@%0d want 0 errs busy@%0d done@%0d",
               err_q.size(), (busy_rise_q.size() > 0) ? busy_rise_q[0] : -1,
               (done_q.size() > 0) ? done_q[0] : -1, t0 + 1, t0 + 82);
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || {got_q[i].idx, got_q[i].val} !== exp_q[i]) begin
        errors++;
        $display("FAIL start_replay_write%0d got %h want %h", i,
                 (i < got_q.size()) ? {got_q[i].idx, got_q[i].val} : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int t0;
    for (int i = 0; i < NUM_TAPS; i++) vals[i] = $urandom;
    bus.cfg_valid = 1'b0;
    @(posedge CLK); #1; cfg_start = 1'b1;
    @(posedge CLK); #1; cfg_start = 1'b0;
    for (int i = 0; i <= 7; i++) push_tap(vals[i]);
    // Now in DRIVE1 of tap 7, tap_Transfer high.
    #2 areset_n = 1'b0;
    #1;
    checks++;
    if ({cfg_busy, cfg_done, cfg_err, tap_Transfer, tap_Index, tap_Value, en_FIR,
         bus.cfg_ready, state_dbg} !== '0) begin
      errors++;
      $display("FAIL async_reset busy=%b xfer=%b idx=%0d val=%h en=%b rdy=%b want all 0",
               cfg_busy, tap_Transfer, tap_Index, tap_Value, en_FIR, bus.cfg_ready);
    end
    bus.cfg_valid = 1'b0;
    #3 areset_n = 1'b1;
    repeat (2) @(posedge CLK);
    // Reset forgets the shadow, so replay is illegal again in either build.
    test_replay_no_shadow();
    for (int i = 0; i < NUM_TAPS; i++) vals[i] = $urandom;
    build_model();
    clear_logs();
    drive_load(1'b0, -1, -1, t0);
    wait_done(200);
    #1;
    checks++;
    if (got_q.size() != NUM_TAPS || done_q.size() != 1 || done_q[0] != t0 + 82) begin
      errors++;
      $display("FAIL reload writes=%0d done@%0d want %0d writes done@%0d", got_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1, NUM_TAPS, t0 + 82);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if ({got_q[i].idx, got_q[i].val} !== exp_q[i] || got_q[i].len != 2) begin
        errors++;
        $display("FAIL reload_write%0d got idx=%0d val=%h want %h", i,
                 got_q[i].idx, got_q[i].val, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_replay_no_shadow();
    test_full_load();
    test_replay_after_load();
    test_stall();
    test_start_during_load();
    test_start_replay_together();
    test_reset_mid_load();
    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_tap_loader.md
# fir_tap_loader

Coefficient-load sequencer for `FIR_Filter_Core`.
- Accepts a full tap set from a host over a valid/ready stream.
- Drives the core's `tap_Transfer`/`tap_Index`/`tap_Value` port with the 3-cycle slot the core's tap-capture FSM requires.
- Holds `en_FIR` low while taps are inconsistent, and for a settle window afterwards, so the core never emits a mixed-coefficient output.
- Sits between the host register interface and the FIR core, in the `CLK` domain.

## Interface
- `NUM_TAPS`, 16, taps per set (indices 0..NUM_TAPS-1)
- `TAP_W`, 32, signed coefficient width
- `IDX_W`, 4, tap index width; must satisfy 2^IDX_W >= NUM_TAPS
- `SETTLE_CYCLES`, 18, cycles `en_FIR` stays low after the last tap write (≥1)

Ports:
- `CLK`  in  1  sole clock, rising edge
- `areset_n`  in  1  reset; asynchronous and active-low, one clock domain
- `user_en`  in  1  host request to run the filter
- `cfg_start`  in  1  one-cycle pulse: begin loading a new tap set
- `cfg_valid`  in  1  `cfg_data` valid
- `cfg_data`  in  TAP_W  coefficient, sent in index order 0 first
- `cfg_ready`  out  1  loader accepts `cfg_data` this cycle
- `cfg_replay`  in  1  one-cycle pulse: rewrite core from shadow store (see Configuration)
- `cfg_busy`  out  1  high in every state except IDLE
- `cfg_done`  out  1  one-cycle pulse: load complete, filter re-enabled
- `cfg_err`  out  1  one-cycle pulse: illegal command, command ignored
- `tap_Transfer`  out  1  to core
- `tap_Index`  out  IDX_W  to core
- `tap_Value`  out  TAP_W  to core
- `en_FIR`  out  1  to core

## Operation
- States: IDLE, WAIT_DATA, DRIVE1, DRIVE2, GAP, SETTLE.
- All outputs are registered. Reset value of every output is 0. Reset clears the index, the settle counter and shadow_valid.
- `en_FIR` = `user_en` registered, qualified by state==IDLE. It is 0 in every other state.
- IDLE + `cfg_start` → WAIT_DATA, index=0.
- WAIT_DATA: `cfg_ready`=1. On `cfg_valid`&&`cfg_ready`, capture `cfg_data` into `tap_Value` and the index into `tap_Index`, then → DRIVE1.
- DRIVE1 and DRIVE2: `tap_Transfer`=1; `tap_Index` and `tap_Value` are held stable.
- GAP: `tap_Transfer`=0, with `tap_Index`/`tap_Value` held.
  - If index==NUM_TAPS-1 → SETTLE with counter=SETTLE_CYCLES-1.
  - Otherwise index+1 → WAIT_DATA.
- SETTLE: decrement the counter. At 0, pulse `cfg_done` and → IDLE.
- `cfg_ready`=0 outside WAIT_DATA. `cfg_valid` without `cfg_ready` is ignored, with no error.
- `cfg_start` or `cfg_replay` while `cfg_busy` → `cfg_err` pulse. The load in progress continues unaffected.
- `cfg_start` and `cfg_replay` asserted together in IDLE → `cfg_start` wins, and no error is raised.
- Host stalls in WAIT_DATA are unbounded. There is no timeout.
- Asserting `areset_n` low mid-load drops every output to 0 at once. The core's taps are then partially written, and the host must reload.

## Timing
- Accept at edge k gives:
  - `tap_Transfer` high in cycles k+1, k+2 and low in k+3.
  - `cfg_ready` high again from k+4.
- Throughput: one tap per 4 cycles with `cfg_valid` held high.
- `cfg_start` at edge s raises `cfg_busy` and `cfg_ready` in cycle s+1.
- `en_FIR` falls in cycle s+1.
- Last GAP ends at edge g. `cfg_done` is high in cycle g+SETTLE_CYCLES, and `en_FIR` rises (if `user_en`) in the cycle after that.
- Minimum full load with NUM_TAPS=16: 1 + 16×4 + 18 cycles from start to done.

## Configuration
- `FIR_TAP_SHADOW_EN` defined:
  - Each accepted coefficient is also written to shadow[index].
  - shadow_valid is set when GAP of index NUM_TAPS-1 completes, and cleared by `cfg_start`.
  - IDLE + `cfg_replay` with shadow_valid runs the same states. WAIT_DATA takes shadow[index] in one cycle without raising `cfg_ready`.
  - `cfg_replay` without shadow_valid → `cfg_err`.
- Not defined:
  - No shadow storage.
  - `cfg_replay` in IDLE always → `cfg_err`, with no state change.

## Test plan
- Reset, then hold `user_en`=1 → `en_FIR`=1 one cycle after reset release; all other outputs 0.
- `cfg_start`, then stream 0x1..0x10 with `cfg_valid` held → 16 `tap_Transfer` pairs, `tap_Index` 0..15, values match, `cfg_done` at cycle 83, `en_FIR` high the cycle after.
- Host drops `cfg_valid` for 10 cycles after tap 5 → `tap_Transfer` stays 0 and `cfg_ready` stays 1; the load resumes and its result is identical.
- `cfg_start` pulsed during DRIVE2 of tap 3 → `cfg_err` pulse, and the load completes normally.
- Reset asserted during tap 7 → all outputs 0 asynchronously. A subsequent full load succeeds.
- With `FIR_TAP_SHADOW_EN`:
  - `cfg_replay` before any load → `cfg_err`.
  - `cfg_replay` after a load → same 16 writes at 4-cycle spacing with `cfg_ready` never high.
